mips_trace_ctrl: RTL and testbench

//  Synthesizable run-control and commit-trace unit for the single-cycle MIPS core: watches each committed PC/IR pair,

---
 rtl/mips_trace_pkg.sv | 18 +
 rtl/trace_ram.sv | 23 ++
 rtl/mips_trace_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mips_trace_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS commit-trace / run-control unit.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2,
    StDump   = 2'd3
  } state_e;

  localparam logic [1:0] HR_NONE    = 2'd0;
  localparam logic [1:0] HR_LOOP    = 2'd1;
  localparam logic [1:0] HR_TIMEOUT = 2'd2;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DW, one write port and one registered read port, no reset.
module trace_ram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mips_trace_ctrl.sv
// Run control and commit trace for the single-cycle MIPS core: self-loop/timeout halt detection
// and an oldest-first valid/ready dump of the last DEPTH commits. TRACE_FILTER_EN adds an opcode filter.
module mips_trace_ctrl
  import mips_trace_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_REPEAT = 3,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned CW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          commit,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ir,
`ifdef TRACE_FILTER_EN
  input  logic [5:0]    filt_op,
  input  logic [5:0]    filt_mask,
`endif
  output logic          running,
  output logic          done,
  output logic [1:0]    halt_reason,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] instr_cnt,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_pc,
  output logic [AW-1:0] dump_ir,
  output logic          dump_last
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(HALT_REPEAT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [RW-1:0] REPEAT_C  = RW'(HALT_REPEAT);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);
  localparam logic [PW:0]   DEPTH_F   = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   ONE_F     = (PW + 1)'(1);

  state_e          state_q, state_d;
  logic [1:0]      halt_reason_q, halt_reason_d;
  logic [CW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CW-1:0]   instr_cnt_q, instr_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     fill_q, fill_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [AW-1:0]   prev_pc_q, prev_pc_d;
  logic            prev_valid_q, prev_valid_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     rd_left_q, rd_left_d;
  logic            pf_valid_q, pf_valid_d;
  logic            pf_last_q, pf_last_d;
  logic            dump_valid_q, dump_valid_d;
  logic            dump_last_q, dump_last_d;
  logic [AW-1:0]   dump_pc_q, dump_pc_d;
  logic [AW-1:0]   dump_ir_q, dump_ir_d;

  logic            ram_we, ram_re;
  logic [PW-1:0]   ram_raddr;
  logic [2*AW-1:0] ram_rdata;

  logic            store_en, start_run, out_free, loop_hit, timeout_hit;
  logic [RW-1:0]   rep_next;
  logic [PW-1:0]   oldest;

`ifdef TRACE_FILTER_EN
  assign store_en = ((ir[OP_MSB:OP_LSB] ^ filt_op) & filt_mask) == 6'd0;
`else
  assign store_en = 1'b1;
`endif

  assign start_run = start && (state_q == StIdle || state_q == StHalted);
  assign out_free  = !dump_valid_q || dump_ready;
  assign oldest    = wr_ptr_q - fill_q[PW-1:0];

  // rep_cnt counts consecutive commits at the same PC, including the first one.
  assign rep_next = (prev_valid_q && pc == prev_pc_q)
                  ? ((rep_cnt_q == REPEAT_C) ? rep_cnt_q : rep_cnt_q + 1'b1)
                  : REP_ONE;
  assign loop_hit    = (state_q == StRun) && commit && (rep_next == REPEAT_C);
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StRun) && (cycle_cnt_q + 1'b1 == TIMEOUT_C);

  always_comb begin
    state_d       = state_q;
    halt_reason_d = halt_reason_q;
    cycle_cnt_d   = cycle_cnt_q;
    instr_cnt_d   = instr_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    rep_cnt_d     = rep_cnt_q;
    prev_pc_d     = prev_pc_q;
    prev_valid_d  = prev_valid_q;
    rd_ptr_d      = rd_ptr_q;
    rd_left_d     = rd_left_q;
    pf_valid_d    = pf_valid_q;
    pf_last_d     = pf_last_q;
    dump_valid_d  = dump_valid_q;
    dump_last_d   = dump_last_q;
    dump_pc_d     = dump_pc_q;
    dump_ir_d     = dump_ir_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_raddr     = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        if (commit) begin
          instr_cnt_d  = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + 1'b1;
          prev_pc_d    = pc;
          prev_valid_d = 1'b1;
          rep_cnt_d    = rep_next;
          if (store_en) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = (fill_q == DEPTH_F) ? fill_q : fill_q + 1'b1;
          end
        end
        if (loop_hit) begin
          state_d       = StHalted;
          halt_reason_d = HR_LOOP;
        end else if (timeout_hit) begin
          state_d       = StHalted;
          halt_reason_d = HR_TIMEOUT;
        end
      end
      StHalted: begin
        if (start) begin
          state_d = StRun;
        end else if (dump_req && fill_q != '0) begin
          // Issue the first read now so the oldest entry reaches the output two cycles later.
          state_d    = StDump;
          ram_re     = 1'b1;
          ram_raddr  = oldest;
          rd_ptr_d   = oldest + 1'b1;
          rd_left_d  = fill_q - ONE_F;
          pf_valid_d = 1'b1;
          pf_last_d  = (fill_q == ONE_F);
        end
      end
      StDump: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          dump_last_d  = 1'b0;
          if (dump_last_q) state_d = StHalted;
        end
        if (out_free && pf_valid_q) begin
          dump_valid_d = 1'b1;
          dump_pc_d    = ram_rdata[2*AW-1:AW];
          dump_ir_d    = ram_rdata[AW-1:0];
          dump_last_d  = pf_last_q;
          pf_valid_d   = 1'b0;
        end
        // The RAM output doubles as the prefetch slot; only refill it once it is being drained.
        if (rd_left_q != '0 && (!pf_valid_q || out_free)) begin
          ram_re     = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_left_d  = rd_left_q - ONE_F;
          pf_valid_d = 1'b1;
          pf_last_d  = (rd_left_q == ONE_F);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_run) begin
      halt_reason_d = HR_NONE;
      cycle_cnt_d   = '0;
      instr_cnt_d   = '0;
      wr_ptr_d      = '0;
      fill_d        = '0;
      rep_cnt_d     = '0;
      prev_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      halt_reason_q <= HR_NONE;
      cycle_cnt_q   <= '0;
      instr_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      rep_cnt_q     <= '0;
      prev_pc_q     <= '0;
      prev_valid_q  <= 1'b0;
      rd_ptr_q      <= '0;
      rd_left_q     <= '0;
      pf_valid_q    <= 1'b0;
      pf_last_q     <= 1'b0;
      dump_valid_q  <= 1'b0;
      dump_last_q   <= 1'b0;
      dump_pc_q     <= '0;
      dump_ir_q     <= '0;
    end else begin
      state_q       <= state_d;
      halt_reason_q <= halt_reason_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_pc_q     <= prev_pc_d;
      prev_valid_q  <= prev_valid_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_left_q     <= rd_left_d;
      pf_valid_q    <= pf_valid_d;
      pf_last_q     <= pf_last_d;
      dump_valid_q  <= dump_valid_d;
      dump_last_q   <= dump_last_d;
      dump_pc_q     <= dump_pc_d;
      dump_ir_q     <= dump_ir_d;
    end
  end

  trace_ram #(
    .DW    (2 * AW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_trace_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({pc, ir}),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign running     = (state_q == StRun);
  assign done        = (state_q == StHalted) || (state_q == StDump);
  assign halt_reason = halt_reason_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instr_cnt   = instr_cnt_q;
  assign dump_valid  = dump_valid_q;
  assign dump_last   = dump_last_q;
  assign dump_pc     = dump_pc_q;
  assign dump_ir     = dump_ir_q;

endmodule

// File: tb/tb_mips_trace_ctrl.sv
// Scoreboard bench for mips_trace_ctrl; the filter scenario runs only when TRACE_FILTER_EN is defined.
module tb_mips_trace_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, commit, dump_req, dump_ready;
  logic [31:0] pc, ir;
  logic        running, done, dump_valid, dump_last;
  logic [1:0]  halt_reason;
  logic [31:0] cycle_cnt, instr_cnt, dump_pc, dump_ir;

  logic        t_start, t_dump_req;
  logic        t_running, t_done, t_dump_valid, t_dump_last;
  logic [1:0]  t_halt_reason;
  logic [31:0] t_cycle_cnt, t_instr_cnt, t_dump_pc, t_dump_ir;
`ifdef TRACE_FILTER_EN
  logic [5:0]  filt_op, filt_mask;
`endif

  beat_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          beats = 0;
  logic        stall_q = 1'b0;
  beat_t       held = '0;
  logic [31:0] p1 [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC};

  always #5 clk = ~clk;

  mips_trace_ctrl #(
    .AW(32), .DEPTH(16), .HALT_REPEAT(3), .TIMEOUT(4096), .CW(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .commit(commit), .pc(pc), .ir(ir),
`ifdef TRACE_FILTER_EN
    .filt_op(filt_op), .filt_mask(filt_mask),
`endif
    .running(running), .done(done), .halt_reason(halt_reason),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .dump_req(dump_req),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_pc(dump_pc),
    .dump_ir(dump_ir), .dump_last(dump_last)
  );

  mips_trace_ctrl #(
    .AW(32), .DEPTH(16), .HALT_REPEAT(3), .TIMEOUT(20), .CW(32)
  ) dut_to (
    .clk(clk), .rst(rst), .start(t_start), .commit(1'b0), .pc(pc), .ir(ir),
`ifdef TRACE_FILTER_EN
    .filt_op(filt_op), .filt_mask(filt_mask),
`endif
    .running(t_running), .done(t_done), .halt_reason(t_halt_reason),
    .cycle_cnt(t_cycle_cnt), .instr_cnt(t_instr_cnt), .dump_req(t_dump_req),
    .dump_valid(t_dump_valid), .dump_ready(1'b1), .dump_pc(t_dump_pc),
    .dump_ir(t_dump_ir), .dump_last(t_dump_last)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] p, input logic [31:0] i, input logic l);
    beat_t b;
    b.pc = p;
    b.ir = i;
    b.last = l;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] p, input logic [31:0] i);
    commit = 1'b1;
    pc = p;
    ir = i;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives dump_ready from a repeating 4-cycle pattern until every expected beat is seen.
  task automatic drain(input string name, input logic [3:0] pat);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      dump_ready = pat[n % 4];
      tick();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d beats never delivered, required 0", name, sb.size());
    end
    dump_ready = 1'b1;
    tick();
    tick();
    check({name, "_idle_valid"}, dump_valid, 1'b0);
    check({name, "_done"}, done, 1'b1);
  endtask

  // Monitor: pops one expectation per accepted beat and checks stall stability.
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    got = {dump_pc, dump_ir, dump_last};
    if (!rst) begin
      if (stall_q) begin
        check("stall_valid", dump_valid, 1'b1);
        check("stall_hold", got, held);
      end
      if (dump_valid && dump_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL beat: got unexpected %h, required no beat", got);
        end else begin
          exp = sb.pop_front();
          check("beat", got, exp);
        end
        beats++;
      end
    end
    stall_q <= !rst && dump_valid && !dump_ready;
    held    <= got;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int b0;
    rst = 1'b1; start = 1'b0; commit = 1'b0; dump_req = 1'b0; dump_ready = 1'b1;
    pc = '0; ir = '0; t_start = 1'b0; t_dump_req = 1'b0;
`ifdef TRACE_FILTER_EN
    filt_op = 6'd0; filt_mask = 6'd0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_reason", halt_reason, 2'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_instr", instr_cnt, 32'd0);
    check("rst_valid", dump_valid, 1'b0);
    check("rst_last", dump_last, 1'b0);
    check("rst_dump_pc", dump_pc, 32'd0);
    check("rst_dump_ir", dump_ir, 32'd0);

    // Self-loop halt after the third commit at 0xC.
    pulse_start();
    check("t1_running", running, 1'b1);
    for (int k = 0; k < 6; k++) begin
      do_commit(p1[k], 32'h2400_0000 + k);
      if (k == 4) check("t1_no_early_halt", running, 1'b1);
    end
    check("t1_done", done, 1'b1);
    check("t1_running_off", running, 1'b0);
    check("t1_reason", halt_reason, 2'd1);
    check("t1_instr", instr_cnt, 32'd6);
    check("t1_cycle", cycle_cnt, 32'd6);
    for (int k = 0; k < 6; k++) sb.push_back(mk(p1[k], 32'h2400_0000 + k, k == 5));
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    check("t1_lat1", dump_valid, 1'b0);
    tick();
    check("t1_lat2", dump_valid, 1'b1);
    drain("t1_dump", 4'b1111);

    // Timeout with no commits on the TIMEOUT=20 instance.
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    repeat (19) tick();
    check("t2_running_19", t_running, 1'b1);
    check("t2_cycle_19", t_cycle_cnt, 32'd19);
    tick();
    check("t2_done", t_done, 1'b1);
    check("t2_cycle", t_cycle_cnt, 32'd20);
    check("t2_reason", t_halt_reason, 2'd2);
    t_dump_req = 1'b1;
    tick();
    t_dump_req = 1'b0;
    tick();
    tick();
    check("t2_no_dump", t_dump_valid, 1'b0);
    check("t2_cycle_hold", t_cycle_cnt, 32'd20);
    check("t2_instr", t_instr_cnt, 32'd0);

    // 40 distinct commits, the 40th PC repeated twice more; restart from HALTED.
    pulse_start();
    check("t3_reason_clr", halt_reason, 2'd0);
    check("t3_cycle_clr", cycle_cnt, 32'd0);
    check("t3_instr_clr", instr_cnt, 32'd0);
    for (int k = 1; k <= 42; k++) begin
      do_commit(32'h1000 + 4 * ((k > 40 ? 40 : k) - 1), 32'h2400_0000 + k);
      if (k == 41) check("t3_no_early_halt", running, 1'b1);
    end
    check("t3_reason", halt_reason, 2'd1);
    check("t3_instr", instr_cnt, 32'd42);
    for (int k = 27; k <= 42; k++)
      sb.push_back(mk(32'h1000 + 4 * ((k > 40 ? 40 : k) - 1), 32'h2400_0000 + k, k == 42));
    b0 = beats;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    drain("t3_dump", 4'b1111);
    check("t3_beats", beats - b0, 16);

    // Same dump replayed with back-pressure 1,0,0,1.
    for (int k = 27; k <= 42; k++)
      sb.push_back(mk(32'h1000 + 4 * ((k > 40 ? 40 : k) - 1), 32'h2400_0000 + k, k == 42));
    b0 = beats;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    drain("t4_dump", 4'b1001);
    check("t4_beats", beats - b0, 16);

    // Reset in the middle of a dump.
    for (int k = 27; k <= 42; k++)
      sb.push_back(mk(32'h1000 + 4 * ((k > 40 ? 40 : k) - 1), 32'h2400_0000 + k, k == 42));
    b0 = beats;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while (beats - b0 < 5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_beats_before_rst", beats - b0, 5);
    rst = 1'b1;
    dump_ready = 1'b0;
    tick();
    check("t5_running", running, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_valid", dump_valid, 1'b0);
    check("t5_reason", halt_reason, 2'd0);
    check("t5_cycle", cycle_cnt, 32'd0);
    check("t5_instr", instr_cnt, 32'd0);
    sb.delete();
    rst = 1'b0;
    dump_ready = 1'b1;
    tick();
    pulse_start();
    check("t5_restart", running, 1'b1);
    do_commit(32'h40, 32'h2400_0100);
    for (int k = 1; k <= 3; k++) do_commit(32'h44, 32'h1000_FFFF);
    check("t5_reason_loop", halt_reason, 2'd1);
    check("t5_instr_after", instr_cnt, 32'd4);
    sb.push_back(mk(32'h40, 32'h2400_0100, 1'b0));
    sb.push_back(mk(32'h44, 32'h1000_FFFF, 1'b0));
    sb.push_back(mk(32'h44, 32'h1000_FFFF, 1'b0));
    sb.push_back(mk(32'h44, 32'h1000_FFFF, 1'b1));
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    drain("t5_dump", 4'b1111);

`ifdef TRACE_FILTER_EN
    // Only beq (opcode 000100) commits are stored; all are counted.
    filt_op = 6'b000100;
    filt_mask = 6'h3F;
    pulse_start();
    do_commit(32'h200, 32'h0085_1021);
    do_commit(32'h204, 32'h1085_0003);
    do_commit(32'h208, 32'h8C82_0000);
    do_commit(32'h20C, 32'h1000_0001);
    do_commit(32'h210, 32'h0043_2021);
    for (int k = 1; k <= 3; k++) do_commit(32'h214, 32'h1000_FFFF);
    check("t6_instr", instr_cnt, 32'd8);
    check("t6_reason", halt_reason, 2'd1);
    sb.push_back(mk(32'h204, 32'h1085_0003, 1'b0));
    sb.push_back(mk(32'h20C, 32'h1000_0001, 1'b0));
    sb.push_back(mk(32'h214, 32'h1000_FFFF, 1'b0));
    sb.push_back(mk(32'h214, 32'h1000_FFFF, 1'b0));
    sb.push_back(mk(32'h214, 32'h1000_FFFF, 1'b1));
    b0 = beats;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    drain("t6_dump", 4'b1111);
    check("t6_beats", beats - b0, 5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
